// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: job start, operand
// streaming with row/column skew, pipeline drain and result handoff.
module systolic_ctrl #(
   parameter int W  = 16,
   parameter int N  = 3,
   parameter int KW = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [KW-1:0]      i_k,
   input  logic               i_mode,
   input  logic [W*N-1:0]     i_a_col,
   input  logic [W*N-1:0]     i_b_row,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   output logic               o_sa_en,
   output logic               o_sa_sync,
   output logic               o_sa_mode,
   output logic [W*N-1:0]     o_sa_A,
   output logic [W*N-1:0]     o_sa_B,
   input  logic [W*N*N-1:0]   i_sa_C,
   output logic [W*N*N-1:0]   o_C,
   output logic               o_c_valid,
   input  logic               i_c_ready,
   output logic               o_busy
);

   localparam int DRAIN_LEN = 2*N - 1;
   localparam int CW = (KW > $clog2(DRAIN_LEN + 1)) ? KW : $clog2(DRAIN_LEN + 1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [KW-1:0]        k_q, k_d;
   logic                 mode_q, mode_d;
   logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
   logic [W*N*N-1:0]     c_q, c_d;
   logic                 skew_clr;
   logic [W*N-1:0]       a_src, b_src;

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      mode_d     = mode_q;
      cnt_d      = cnt_q;
      c_d        = c_q;
      o_in_ready = 1'b0;
      o_sa_en    = 1'b0;
      o_sa_sync  = 1'b0;
      o_c_valid  = 1'b0;
      skew_clr   = 1'b0;
      a_src      = '0;
      b_src      = '0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               k_d     = i_k;
               mode_d  = i_mode;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            o_sa_sync = 1'b1;
            o_sa_en   = 1'b1;
            skew_clr  = 1'b1;
            cnt_d     = '0;
            if (k_q == '0) begin
               c_d     = '0;
               state_d = S_DONE;
            end else begin
               state_d = S_FEED;
            end
         end
         S_FEED: begin
            o_in_ready = 1'b1;
            a_src      = i_a_col;
            b_src      = i_b_row;
            // A stalled beat freezes both the skew pipeline and the array.
            if (i_in_valid) begin
               o_sa_en = 1'b1;
               cnt_d   = cnt_inc;
               if (cnt_inc == CW'(k_q)) begin
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            o_sa_en = 1'b1;
            cnt_d   = cnt_inc;
            if (cnt_q == CW'(DRAIN_LEN - 1)) begin
               c_d     = i_sa_C;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            o_c_valid = 1'b1;
            if (i_c_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
      end
   end

   assign o_sa_mode = (state_q != S_IDLE) && mode_q;
   assign o_busy    = (state_q != S_IDLE);
   assign o_C       = c_q;

   assign o_sa_A[W-1:0] = a_src[W-1:0];
   assign o_sa_B[W-1:0] = b_src[W-1:0];

   // Lane gi carries a gi-deep shift register; its output is forced to zero
   // during CLEAR so the array sees only zeros while accumulators reset.
   genvar gi;
   for (gi = 1; gi < N; gi++) begin : g_skew
      logic [W-1:0] a_sr_q [0:gi-1];
      logic [W-1:0] a_sr_d [0:gi-1];
      logic [W-1:0] b_sr_q [0:gi-1];
      logic [W-1:0] b_sr_d [0:gi-1];

      always_comb begin
         for (int s = 0; s < gi; s++) begin
            a_sr_d[s] = a_sr_q[s];
            b_sr_d[s] = b_sr_q[s];
         end
         if (skew_clr) begin
            for (int s = 0; s < gi; s++) begin
               a_sr_d[s] = '0;
               b_sr_d[s] = '0;
            end
         end else if (o_sa_en) begin
            a_sr_d[0] = a_src[gi*W +: W];
            b_sr_d[0] = b_src[gi*W +: W];
            for (int s = 1; s < gi; s++) begin
               a_sr_d[s] = a_sr_q[s-1];
               b_sr_d[s] = b_sr_q[s-1];
            end
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            for (int s = 0; s < gi; s++) begin
               a_sr_q[s] <= '0;
               b_sr_q[s] <= '0;
            end
         end else begin
            for (int s = 0; s < gi; s++) begin
               a_sr_q[s] <= a_sr_d[s];
               b_sr_q[s] <= b_sr_d[s];
            end
         end
      end

      assign o_sa_A[gi*W +: W] = skew_clr ? '0 : a_sr_q[gi-1];
      assign o_sa_B[gi*W +: W] = skew_clr ? '0 : b_sr_q[gi-1];
   end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for the N×N output-stationary systolic multiply array. It accepts a job start, then accepts K beats of operands over a valid/ready stream, one column of A and one row of B per beat. It applies the row/column skew the array needs, drives the array's enable, clear-sync and mode inputs, and drains the pipeline. When the job is done it registers the array's packed result and hands it out through a valid/ready handshake.

## Interface
- W, 16: operand/result lane width
- N, 3: array dimension (rows = columns = N)
- KW, 8: width of the beat-count field; K ranges 0..2^KW-1
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  job start request; sampled only in IDLE
- i_k  in  KW  number of operand beats K, captured with i_start
- i_mode  in  1  array mode, captured with i_start
- i_a_col  in  W*N  lane i = A[i][k]
- i_b_row  in  W*N  lane j = B[k][j]
- i_in_valid  in  1  operand beat valid
- o_in_ready  out  1  operand beat ready
- o_sa_en  out  1  array enable
- o_sa_sync  out  1  array accumulator clear pulse
- o_sa_mode  out  1  array mode (held for the whole job)
- o_sa_A  out  W*N  skewed A lanes to array rows
- o_sa_B  out  W*N  skewed B lanes to array columns
- i_sa_C  in  W*N*N  array result; lane (i*N+j) at [(i*N+j)*W +: W]
- o_C  out  W*N*N  registered result, same packing
- o_c_valid  out  1  result valid
- i_c_ready  in  1  result consumer ready
- o_busy  out  1  high in every state except IDLE

## Operation
- State machine: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: o_in_ready=0, o_sa_en=0. On i_start, capture i_k and i_mode, then go to CLEAR.
- CLEAR: held for 1 cycle. o_sa_sync=1, o_sa_en=1, all A/B lanes 0, and the skew registers are cleared. Next state is FEED if K≠0, else DONE (result all zero).
- FEED: o_in_ready=1. A beat is accepted when i_in_valid=1 and o_in_ready=1.
  - Accepted beat: o_sa_en=1, the skew pipeline advances, and the beat counter increments.
  - No beat: o_sa_en=0, and the skew pipeline and array hold.
  - After beat K is accepted, go to DRAIN.
- Skew: A lane i is delayed by i enabled cycles and B lane j by j enabled cycles. Lane 0 passes through combinationally and the other lanes come from shift registers. The registers advance only when o_sa_en=1.
- DRAIN: lasts 2N-1 cycles. o_sa_en=1 and zeros enter lane 0 of the skew pipeline. On the final DRAIN edge, o_C <= i_sa_C and the state moves to DONE.
- DONE: o_c_valid=1 and o_C is held stable. When i_c_ready=1, go to IDLE and clear o_c_valid. For K=0, o_C <= 0 on entry to DONE.
- o_sa_mode equals the captured mode from CLEAR through DONE, and 0 in IDLE.
- i_start outside IDLE is ignored. It is not queued.
- Arithmetic belongs to the array. The controller never modifies lane values.

## Timing
- Reset values: state=IDLE; o_in_ready, o_sa_en, o_sa_sync, o_sa_mode, o_c_valid and o_busy are 0; o_sa_A, o_sa_B, o_C and all skew registers are 0.
- Reset mid-job (any state) aborts the job at the next edge with the same values. Any pending result is discarded.
- Latency with no stalls: if i_start is sampled at edge e0, o_c_valid rises after edge e0+K+2N. For N=3 and K=3 that is e0+9, the 10th cycle after start. Each input stall cycle adds 1.
- In FEED, o_in_ready does not depend on i_in_valid.
- o_c_valid, once high, stays high until the handshake completes. o_C does not change while o_c_valid=1.
- Back-to-back: the earliest next start is sampled in the first IDLE cycle after the DONE handshake.
- o_sa_sync is never high outside CLEAR.

## Test plan
- Identity: N=3, K=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=I, no stalls → o_c_valid after e0+9, o_C lanes = 1..9 in row-major order.
- Constant: A all 2, B all 3, K=3, i_in_valid deasserted on alternating cycles → every C lane = 18; o_sa_en low exactly on the stall cycles; latency = 9+3.
- Output backpressure: i_c_ready held low 5 cycles in DONE → o_c_valid and o_C stable all 5 cycles; i_start pulsed in DONE ignored; IDLE after the handshake.
- K=0: start → CLEAR, then DONE with o_C=0 and o_c_valid high one cycle after CLEAR; no operand beats accepted.
- Reset mid-FEED after 2 beats → next cycle all outputs at reset values. A new job (A=B=I) then gives C=I with no residue.
- Back-to-back jobs: second job with A all 1, B all 1 → every lane 3. This checks that the CLEAR sync pulse fires once per job.
